// File: rtl/fa_bist_pkg.sv
// Shared types and golden model for the full-adder BIST engine.
// Latency: n/a (types and pure function only).
// Backpressure: n/a.
package fa_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int         N_VEC    = 8;
  localparam logic [3:0] FAIL_SAT = 4'd8;

  // Golden full-adder response for vector {A,B,C}, returned as {carry,sum}.
  function automatic logic [1:0] fa_golden(input logic [2:0] v);
    logic s;
    logic c;
    s = v[2] ^ v[1] ^ v[0];
    c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return {c, s};
  endfunction

endpackage

// File: rtl/fa_bist_settle_timer.sv
// Loadable 4-bit down-counter with zero flag, paces the adder settle time.
// Latency: load or decrement visible one cycle later; zero flag is combinational on the count.
// Backpressure: none; holds at zero when decremented past it.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fa_bist.sv
// BIST engine: drives all 8 full-adder vectors, checks Sum/Carry, reports pass and first failure.
// Latency: 8*(SETTLE+1)+7 cycles of run after the start edge, then done; all outputs registered.
// Backpressure: none; start is ignored while busy and only sampled in IDLE or DONE.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       sum_in,
  input  logic       carry_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_cnt,
  output logic [2:0] fail_vec,
  output logic [1:0] fail_bits
);

  // Counter reload value: WAIT spends SETTLE cycles including the one where the count hits zero.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [2:0] LAST_VEC  = 3'(N_VEC - 1);

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] stim_q, stim_d;
  logic [3:0] fail_cnt_q, fail_cnt_d;
  logic [2:0] fail_vec_q, fail_vec_d;
  logic [1:0] fail_bits_q, fail_bits_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;
  logic [1:0] exp_resp;
  logic [1:0] err_bits;

  settle_timer #(.W(4)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign exp_resp = fa_golden(stim_q);
  assign err_bits = {carry_in ^ exp_resp[1], sum_in ^ exp_resp[0]};

  // Next-state, datapath updates and next values of the registered status outputs.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    stim_d      = stim_q;
    fail_cnt_d  = fail_cnt_q;
    fail_vec_d  = fail_vec_q;
    fail_bits_d = fail_bits_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d       = '0;
          stim_d      = '0;
          fail_cnt_d  = '0;
          fail_vec_d  = '0;
          fail_bits_d = '0;
          tmr_load    = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (err_bits != 2'b00) begin
          if (fail_cnt_q < FAIL_SAT) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
          // An empty count means this is the first failure of the run.
          if (fail_cnt_q == '0) begin
            fail_vec_d  = stim_q;
            fail_bits_d = err_bits;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          stim_d  = vec_q + 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (fail_cnt_d == '0);
  end

  // State and result registers; reset aborts any run with no partial results kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      stim_q      <= '0;
      fail_cnt_q  <= '0;
      fail_vec_q  <= '0;
      fail_bits_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      stim_q      <= stim_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_vec_q  <= fail_vec_d;
      fail_bits_q <= fail_bits_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign a_out     = stim_q[2];
  assign b_out     = stim_q[1];
  assign c_out     = stim_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_cnt  = fail_cnt_q;
  assign fail_vec  = fail_vec_q;
  assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_fa_bist.sv
// Testbench for fa_bist: full-adder models with injectable per-vector faults,
// reference results computed from adder arithmetic, run-length and stepping checks.
module tb_fa_bist;

  logic clk;
  logic rst;
  logic start;
  logic start1;
  logic start15;

  int n_cmp;
  int n_err;

  // Per-vector fault mask {carry_flip, sum_flip} applied to the main DUT's adder.
  logic [1:0] fault_tbl [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder: the response is the 2-bit count of ones in {A,B,C}.
  function automatic logic [1:0] adder_ref(input logic a, input logic b, input logic c);
    int n;
    n = int'(a) + int'(b) + int'(c);
    return 2'(n);
  endfunction

  // ---------------- main DUT, SETTLE = 2 ----------------
  logic       a2, b2, c2, sum2, carry2, busy2, done2, pass2;
  logic [3:0] fcnt2;
  logic [2:0] fvec2;
  logic [1:0] fbits2;
  logic [1:0] resp2;

  assign resp2  = adder_ref(a2, b2, c2) ^ fault_tbl[{a2, b2, c2}];
  assign sum2   = resp2[0];
  assign carry2 = resp2[1];

  fa_bist #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a2), .b_out(b2), .c_out(c2),
    .sum_in(sum2), .carry_in(carry2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_cnt(fcnt2), .fail_vec(fvec2), .fail_bits(fbits2)
  );

  // ---------------- SETTLE = 1 build, healthy adder ----------------
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] fcnt1;
  logic [2:0] fvec1;
  logic [1:0] fbits1;
  logic [1:0] resp1;

  assign resp1 = adder_ref(a1, b1, c1);

  fa_bist #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_out(a1), .b_out(b1), .c_out(c1),
    .sum_in(resp1[0]), .carry_in(resp1[1]),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_cnt(fcnt1), .fail_vec(fvec1), .fail_bits(fbits1)
  );

  // ---------------- SETTLE = 15 build, healthy adder ----------------
  logic       a15, b15, c15, busy15, done15, pass15;
  logic [3:0] fcnt15;
  logic [2:0] fvec15;
  logic [1:0] fbits15;
  logic [1:0] resp15;

  assign resp15 = adder_ref(a15, b15, c15);

  fa_bist #(.SETTLE(15)) dut_s15 (
    .clk(clk), .rst(rst), .start(start15),
    .a_out(a15), .b_out(b15), .c_out(c15),
    .sum_in(resp15[0]), .carry_in(resp15[1]),
    .busy(busy15), .done(done15), .pass(pass15),
    .fail_cnt(fcnt15), .fail_vec(fvec15), .fail_bits(fbits15)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run on the main DUT and checks timing, stimulus order and results
  // against the fault table. With hold_start, start stays high throughout.
  task automatic run_main(input string tag, input bit hold_start);
    int         cyc;
    int         steps;
    int         nf;
    int         fv;
    int         fb;
    logic [2:0] prev;
    nf = 0; fv = 0; fb = 0;
    for (int v = 0; v < 8; v++) begin
      if (fault_tbl[v] != 2'b00) begin
        if (nf == 0) begin
          fv = v;
          fb = int'(fault_tbl[v]);
        end
        nf++;
      end
    end
    start = 1'b1;
    cyc   = 0;
    steps = 0;
    prev  = 3'd0;
    while (cyc < 300) begin
      tick();
      if (!hold_start) start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        check({tag, "_stim0"}, int'({a2, b2, c2}), 0);
        check({tag, "_busy"}, int'(busy2), 1);
      end else if ({a2, b2, c2} != prev) begin
        check({tag, "_stim_step"}, int'({a2, b2, c2}), int'(prev) + 1);
        steps++;
      end
      prev = {a2, b2, c2};
      if (done2) break;
    end
    check({tag, "_run_len"}, cyc, 32);
    check({tag, "_steps"}, steps, 7);
    check({tag, "_done"}, int'(done2), 1);
    check({tag, "_busy_at_done"}, int'(busy2), 0);
    check({tag, "_pass"}, int'(pass2), (nf == 0) ? 1 : 0);
    check({tag, "_fail_cnt"}, int'(fcnt2), nf);
    check({tag, "_fail_vec"}, int'(fvec2), fv);
    check({tag, "_fail_bits"}, int'(fbits2), fb);
  endtask

  initial begin
    int cyc;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    start1  = 1'b0;
    start15 = 1'b0;
    for (int v = 0; v < 8; v++) fault_tbl[v] = 2'b00;

    // Reset state.
    repeat (3) tick();
    check("rst_outputs", int'({a2, b2, c2, busy2, done2, pass2, fcnt2, fvec2, fbits2}), 0);
    rst = 1'b0;
    tick();
    check("idle_outputs", int'({a2, b2, c2, busy2, done2, pass2, fcnt2, fvec2, fbits2}), 0);

    // Healthy adder.
    run_main("clean", 1'b0);

    // Sum stuck-at-0: vectors with odd parity fail on sum only.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      fault_tbl[v] = {1'b0, adder_ref(vv[2], vv[1], vv[0]) & 2'b01};
    end
    run_main("sum_sa0", 1'b0);
    check("sum_sa0_cnt_const", int'(fcnt2), 4);
    check("sum_sa0_vec_const", int'(fvec2), 1);
    check("sum_sa0_bits_const", int'(fbits2), 1);

    // Carry inverted on every vector: count saturates at 8.
    for (int v = 0; v < 8; v++) fault_tbl[v] = 2'b10;
    run_main("carry_inv", 1'b0);
    check("carry_inv_cnt_const", int'(fcnt2), 8);

    // Random fault patterns.
    for (int t = 0; t < 6; t++) begin
      for (int v = 0; v < 8; v++) begin
        fault_tbl[v] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      end
      run_main("random", 1'b0);
    end
    for (int v = 0; v < 8; v++) fault_tbl[v] = 2'b00;

    // Reset in the middle of a run.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("midrun_busy", int'(busy2), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_outputs", int'({a2, b2, c2, busy2, done2, pass2, fcnt2, fvec2, fbits2}), 0);
    check("midrun_rst_state", int'(dut.state_q), 0);
    run_main("after_rst", 1'b0);

    // Reset and start together: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", int'(busy2), 0);
    check("rst_start_done", int'(done2), 0);

    // Start held high: ignored while busy, restarts straight from DONE.
    run_main("hold", 1'b1);
    tick();
    start = 1'b0;
    check("hold_done_one_cycle", int'(done2), 0);
    check("hold_restart_busy", int'(busy2), 1);
    cyc = 0;
    while (!done2 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("hold_rerun_len", cyc, 31);
    check("hold_rerun_pass", int'(pass2), 1);

    // SETTLE = 1 build.
    start1 = 1'b1;
    cyc    = 0;
    while (cyc < 300) begin
      tick();
      start1 = 1'b0;
      cyc++;
      if (done1) break;
    end
    check("s1_run_len", cyc, 24);
    check("s1_pass", int'(pass1), 1);
    check("s1_fail_cnt", int'(fcnt1), 0);
    check("s1_stim_last", int'({a1, b1, c1}), 7);

    // SETTLE = 15 build.
    start15 = 1'b1;
    cyc     = 0;
    while (cyc < 400) begin
      tick();
      start15 = 1'b0;
      cyc++;
      if (done15) break;
    end
    check("s15_run_len", cyc, 136);
    check("s15_pass", int'(pass15), 1);
    check("s15_fail_cnt", int'(fcnt15), 0);
    check("s15_fail_info", int'({fvec15, fbits15}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fa_bist.md
# fa_bist

Built-in self-test engine for the lab full-adder datapath, the response-checking counterpart to the stimulus sequence applied in simulation. It drives all 8 input combinations (A,B,C = 000 to 111) into a combinational full adder and samples Sum/Carry after a programmable settle time. It compares each sample with the golden value and reports pass/fail, the first failing vector and an error count. It sits beside the adder under test, on the same board clock, controlled by a push-button start.

## Interface
- `SETTLE`, default 2: clock cycles between driving a vector and sampling the response; legal range 1–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled only in IDLE and DONE; launches a run.
- `a_out`, `b_out`, `c_out`  out  1 each  stimulus to the adder under test; registered.
- `sum_in`, `carry_in`  in  1 each  adder response; sampled only in CHECK.
- `busy`  out  1  high in APPLY, WAIT and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`; 1 means `fail_cnt`==0.
- `fail_cnt`  out  4  number of failing vectors, 0–8; saturates at 8.
- `fail_vec`  out  3  {A,B,C} of the first failing vector; 0 when none failed.
- `fail_bits`  out  2  {carry_err, sum_err} of the first failing vector.

## Operation
- Reset value of every output is 0, including the stimulus, `busy`, `done`, `pass`, `fail_cnt`, `fail_vec` and `fail_bits`. State resets to IDLE and the vector counter `vec` to 0.
- **IDLE:** if `start`, then on the next edge:
  - `vec` and the error registers are cleared;
  - the stimulus becomes 000;
  - the FSM goes to WAIT with the settle counter loaded to `SETTLE`-1.
- **WAIT:** the settle counter decrements each cycle; at 0 the FSM goes to CHECK.
- **CHECK:** one cycle.
  - Expected Sum = A^B^C; expected Carry = AB | AC | BC.
  - On a mismatch, `fail_cnt` increments (saturating at 8).
  - If this is the first failure, `fail_vec` takes {A,B,C} and `fail_bits` takes {carry mismatch, sum mismatch}.
  - If `vec`==7, the FSM goes to DONE.
  - Otherwise `vec` increments, the stimulus becomes `vec`+1 and the FSM goes to APPLY.
- **APPLY:** one cycle, load the settle counter, go to WAIT. The stimulus is already stable, so APPLY adds margin only.
- **DONE:** `done`=1. `pass` = (`fail_cnt`==0). The results hold until a restart.
  - `start` high goes directly to the IDLE-start action (clear, vector 000, WAIT).
  - `done` drops on that edge.
- The stimulus is held constant from the edge that drives it through its CHECK cycle.
- `vec` never wraps during a run: the 3-bit counter reaching 7 terminates the run rather than overflowing to 0.
- `start` is ignored while `busy`.
- `rst` mid-run aborts immediately to the reset values on that edge; no partial results are retained.
- If `rst` and `start` are high in the same cycle, `rst` wins.

## Timing
- Run length for vector 0, from the start edge: WAIT takes `SETTLE` cycles, then CHECK takes 1 cycle.
- Each subsequent vector costs 1 (APPLY) + `SETTLE` + 1 (CHECK) cycles.
- Total from start edge to `done`=1: 8·(`SETTLE`+1) + 7 + 1 cycles. With `SETTLE`=2 this is 32 cycles.
- `sum_in`/`carry_in` are sampled combinationally only in the CHECK cycle. The adder's path must settle within `SETTLE` cycles.
- All outputs are registered; no combinational path from input to output.

## Structure
- Shared package `fa_bist_pkg`:
  - state encoding IDLE=0, APPLY=1, WAIT=2, CHECK=3, DONE=4 (3 bits);
  - `N_VEC`=8;
  - a golden-model function returning {carry,sum} for a 3-bit vector.
- One natural sub-module: `settle_timer`, a loadable down-counter with a zero flag, width 4.
- The FSM, vector counter and result registers stay in `fa_bist`.

## Test plan
- Correct adder, `SETTLE`=2:
  - pulse `start`;
  - expect `done`=1 exactly 32 cycles after the start edge, `pass`=1, `fail_cnt`=0, `fail_vec`=0, `fail_bits`=00;
  - expect the stimulus to step 000…111 in order.
- Adder with Sum stuck-at-0: expect `pass`=0, `fail_cnt`=4, `fail_vec`=001, `fail_bits`=01.
- Adder with Carry inverted: expect `fail_cnt`=8 (saturated), `fail_vec`=000, `fail_bits`=10.
- Assert `rst` at cycle 10 of a run:
  - expect all outputs 0 and state IDLE next cycle;
  - `start` afterwards runs a full clean pass.
- `start` held high throughout the run: it has no effect while `busy`; at DONE it restarts immediately (`done` high for exactly 1 cycle).
- `SETTLE`=1 and `SETTLE`=15 builds: expect run lengths of 24 and 136 cycles respectively, with correct results.
